coin_input_conditioner: RTL and testbench
=========================================

Name: coin_input_conditioner

Overview:
- Front-end stage that feeds the drink vending FSM.
- Takes two raw, bouncing, asynchronous mechanical coin sensors (50 cents and 1 yuan) and produces the clean 2-bit coin code X that the FSM consumes.
- Each physical insertion yields exactly one single-cycle nonzero code. Nonzero codes are always separated by at least one 2'b00 cycle, so the FSM's "X changed" detection never merges or drops coins.
- Also flags jammed sensors and lost events.

Parameters:
- DEBOUNCE_CNT, 3: consecutive CP_20ms samples a synchronized input must differ from its stable value before the stable value flips (3 = 60 ms). Legal range ≥ 2.
- JAM_CNT, 50: consecutive cycles a stable-high channel may stay high before its jam flag asserts (50 = 1 s). Must be > DEBOUNCE_CNT.

Ports:
- CP_20ms  input  1  system clock, 20 ms period, rising edge.
- Rst_async_n  input  1  reset, asynchronous, active-low.
- coin_50_raw  input  1  raw 50-cent sensor, asynchronous, high = coin present.
- coin_100_raw  input  1  raw 1-yuan sensor, asynchronous, high = coin present.
- X  output  2  coin code to the FSM, registered: 00 none, 01 fifty cents, 10 one yuan. 11 is never driven.
- jam_50  output  1  50-cent channel jammed (level).
- jam_100  output  1  1-yuan channel jammed (level).
- lost_evt  output  1  sticky: an insertion was dropped. Cleared only by reset.

Behaviour:
- Reset (async, Rst_async_n=0):
  - X=00, jam_50=0, jam_100=0, lost_evt=0.
  - All synchronizers, stable bits, counters, arm bits and pending bits = 0.
  - FSM = IDLE.
  - Reset mid-emission forces X=00 immediately, without waiting for a clock edge.
- Per channel, identical logic:
  - Sync: two-flop synchronizer on the raw input gives s.
  - Debounce: a counter increments each edge while s != stable and clears when s == stable. On the edge where DEBOUNCE_CNT consecutive mismatches are reached, stable <= s and the counter clears. Pulses shorter than DEBOUNCE_CNT cycles are ignored.
  - Arm: cleared by reset; set when stable is low and has completed a debounce of low (i.e. DEBOUNCE_CNT low samples after reset). An unarmed channel never raises pending, so a coin held through reset is not counted.
  - Rise: on the edge where stable goes 0->1 and the channel is armed, set pending. If pending is already set, keep it, set lost_evt=1, and count no second event.
  - Jam: a counter of width $clog2(JAM_CNT+1), saturating, counts while stable=1 and clears when stable=0. jam_x=1 when the count reaches JAM_CNT and stays 1 until stable returns to 0. Jam does not suppress the event already pending.
- Emit FSM (registered X):
  - IDLE:
    - if pend_50, go to EMIT50, set X=01 and clear pend_50;
    - else if pend_100, go to EMIT100, set X=10 and clear pend_100;
    - else stay in IDLE with X=00.
  - EMIT50 / EMIT100: go to GAP with X=00, unconditionally after one cycle.
  - GAP: go to IDLE with X=00, unconditionally.
  - Illegal state encodings recover to IDLE with X=00.
- Priority: 50 cents over 1 yuan when both are pending. The 1-yuan coin is emitted after the GAP, so an X sequence is 01,00,00,10 worst case.
- Latency: raw high is first sampled at edge 0 and held. stable rises and pending is set at edge DEBOUNCE_CNT+1. X shows the code after edge DEBOUNCE_CNT+2 (edge 5 by default), provided the FSM is in IDLE. Otherwise the code is delayed until the FSM returns to IDLE, at most 2 extra cycles.
- Ordering: a pending bit set on the same edge the FSM leaves IDLE waits for the next IDLE.
- Throughput: at most one coin per 3 cycles total.

Decomposition:
- Shared package holds:
  - coin codes NO_INPUT=2'b00, FIFTY_CENTS=2'b01, ONE_YUAN=2'b10, which the vending FSM also uses;
  - emit-FSM state encodings IDLE, EMIT50, EMIT100, GAP;
  - default values for DEBOUNCE_CNT and JAM_CNT.
- One sub-module, coin_debounce, contains the synchronizer, debounce counter, arm bit, rise detect and jam counter. It has outputs rise and jam, and is instantiated twice.
- The top level holds the pending bits, lost_evt and the emit FSM.

Test Plan:
- Clean coin: coin_50_raw high from edge 0 for 10 cycles, after reset and arming.
  - Required: X=01 for exactly one cycle after edge 5, 00 otherwise; jam_50=0.
- Bounce: coin_100_raw samples 1,0,1,1,0 then 1 held for 8 cycles.
  - Required: exactly one X=10 pulse, no 01, lost_evt=0.
- Glitch: coin_50_raw high for 2 cycles only.
  - Required: X stays 00 throughout.
- Simultaneous coins: both raw inputs rise at edge 0.
  - Required: X=01 after edge 5, 00 after edges 6 and 7, 10 after edge 8, then 00.
- Repeated coins: two 50-cent coins, each high 4 cycles, separated by 4 low cycles.
  - Required: two separate 01 pulses with ≥1 cycle of 00 between them.
- Reset cases:
  - coin_50_raw held high through reset release and for 60 cycles: no X event; jam_50=1 from cycle JAM_CNT after stable rises.
  - Reset asserted during an X=10 cycle: X=00 immediately.

Source files
------------

// File: rtl/coin_input_conditioner_pkg.sv
// Shared coin codes, emit-FSM encodings and default timing parameters for the
// coin front end and the vending FSM.
package coin_input_conditioner_pkg;

  localparam logic [1:0] NO_INPUT    = 2'b00;
  localparam logic [1:0] FIFTY_CENTS = 2'b01;
  localparam logic [1:0] ONE_YUAN    = 2'b10;

  localparam logic [1:0] IDLE    = 2'b00;
  localparam logic [1:0] EMIT50  = 2'b01;
  localparam logic [1:0] EMIT100 = 2'b10;
  localparam logic [1:0] GAP     = 2'b11;

  localparam int unsigned DEBOUNCE_CNT_DEF = 3;
  localparam int unsigned JAM_CNT_DEF      = 50;

endpackage

// File: rtl/coin_debounce.sv
// One coin sensor channel: synchronizer, debounce, arming after a clean low,
// rising-edge event and jam detection.
module coin_debounce
  import coin_input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CNT = DEBOUNCE_CNT_DEF,
  parameter int unsigned JAM_CNT      = JAM_CNT_DEF
) (
  input  logic CP_20ms,
  input  logic Rst_async_n,
  input  logic raw,
  output logic rise,
  output logic jam
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CNT + 1);
  localparam int unsigned JW = $clog2(JAM_CNT + 1);

  logic          s1;
  logic          s;
  logic          stable;
  logic          armed;
  logic          flip;
  logic [DW-1:0] db_cnt;
  logic [DW-1:0] arm_cnt;
  logic [JW-1:0] jam_cnt;

  assign flip = (s != stable) && (db_cnt == DW'(DEBOUNCE_CNT - 1));
  // Event is raised on the same edge stable flips so the top can latch it there.
  assign rise = flip && s && armed;
  assign jam  = stable && (jam_cnt == JW'(JAM_CNT));

  always_ff @(posedge CP_20ms or negedge Rst_async_n) begin
    if (!Rst_async_n) begin
      s1      <= 1'b0;
      s       <= 1'b0;
      stable  <= 1'b0;
      armed   <= 1'b0;
      db_cnt  <= '0;
      arm_cnt <= '0;
      jam_cnt <= '0;
    end else begin
      s1 <= raw;
      s  <= s1;

      if (s != stable) begin
        if (flip) begin
          stable <= s;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DW'(1);
        end
      end else begin
        db_cnt <= '0;
      end

      // Arming needs DEBOUNCE_CNT consecutive low samples; this coincides with
      // a debounced fall when the coin was held through reset.
      if (!armed) begin
        if (s) begin
          arm_cnt <= '0;
        end else if (arm_cnt == DW'(DEBOUNCE_CNT - 1)) begin
          armed   <= 1'b1;
          arm_cnt <= '0;
        end else begin
          arm_cnt <= arm_cnt + DW'(1);
        end
      end

      if (!stable) begin
        jam_cnt <= '0;
      end else if (jam_cnt != JW'(JAM_CNT)) begin
        jam_cnt <= jam_cnt + JW'(1);
      end
    end
  end

endmodule

// File: rtl/coin_input_conditioner.sv
// Turns two bouncing coin sensors into single-cycle coin codes separated by
// idle cycles, with jam and lost-event flags.
module coin_input_conditioner
  import coin_input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CNT = DEBOUNCE_CNT_DEF,
  parameter int unsigned JAM_CNT      = JAM_CNT_DEF
) (
  input  logic       CP_20ms,
  input  logic       Rst_async_n,
  input  logic       coin_50_raw,
  input  logic       coin_100_raw,
  output logic [1:0] X,
  output logic       jam_50,
  output logic       jam_100,
  output logic       lost_evt
);

  logic       rise_50;
  logic       rise_100;
  logic       pend_50;
  logic       pend_100;
  logic       take_50;
  logic       take_100;
  logic [1:0] state;

  coin_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT), .JAM_CNT(JAM_CNT)) u_ch50 (
    .CP_20ms     (CP_20ms),
    .Rst_async_n (Rst_async_n),
    .raw         (coin_50_raw),
    .rise        (rise_50),
    .jam         (jam_50)
  );

  coin_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT), .JAM_CNT(JAM_CNT)) u_ch100 (
    .CP_20ms     (CP_20ms),
    .Rst_async_n (Rst_async_n),
    .raw         (coin_100_raw),
    .rise        (rise_100),
    .jam         (jam_100)
  );

  assign take_50  = (state == IDLE) && pend_50;
  assign take_100 = (state == IDLE) && !pend_50 && pend_100;

  always_ff @(posedge CP_20ms or negedge Rst_async_n) begin
    if (!Rst_async_n) begin
      state    <= IDLE;
      X        <= NO_INPUT;
      pend_50  <= 1'b0;
      pend_100 <= 1'b0;
      lost_evt <= 1'b0;
    end else begin
      // A pending bit consumed on this edge frees the slot for a new rise.
      pend_50  <= rise_50  | (pend_50  & ~take_50);
      pend_100 <= rise_100 | (pend_100 & ~take_100);
      if ((rise_50 && pend_50 && !take_50) || (rise_100 && pend_100 && !take_100))
        lost_evt <= 1'b1;

      case (state)
        IDLE: begin
          if (take_50) begin
            state <= EMIT50;
            X     <= FIFTY_CENTS;
          end else if (take_100) begin
            state <= EMIT100;
            X     <= ONE_YUAN;
          end else begin
            X     <= NO_INPUT;
          end
        end
        EMIT50, EMIT100: begin
          state <= GAP;
          X     <= NO_INPUT;
        end
        GAP: begin
          state <= IDLE;
          X     <= NO_INPUT;
        end
        default: begin
          state <= IDLE;
          X     <= NO_INPUT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Directed bench for coin_input_conditioner; each scenario checks X, jam and
// lost_evt against hand-derived cycle-by-cycle expectations.
module tb_coin_input_conditioner;

  logic       CP_20ms = 1'b0;
  logic       Rst_async_n = 1'b0;
  logic       coin_50_raw = 1'b0;
  logic       coin_100_raw = 1'b0;
  logic [1:0] X;
  logic       jam_50;
  logic       jam_100;
  logic       lost_evt;

  int tests = 0;
  int fails = 0;

  coin_input_conditioner #(.DEBOUNCE_CNT(3), .JAM_CNT(50)) dut (
    .CP_20ms      (CP_20ms),
    .Rst_async_n  (Rst_async_n),
    .coin_50_raw  (coin_50_raw),
    .coin_100_raw (coin_100_raw),
    .X            (X),
    .jam_50       (jam_50),
    .jam_100      (jam_100),
    .lost_evt     (lost_evt)
  );

  always #10 CP_20ms = ~CP_20ms;

  task automatic tick();
    @(posedge CP_20ms);
    #1;
  endtask

  task automatic idle(input int n);
    coin_50_raw  = 1'b0;
    coin_100_raw = 1'b0;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    #5;
    tests++;
    if (X !== 2'b00) begin fails++; $display("FAIL reset_X got=%b exp=00", X); end
    tests++;
    if (jam_50 !== 1'b0 || jam_100 !== 1'b0) begin
      fails++; $display("FAIL reset_jam got=%b%b exp=00", jam_50, jam_100);
    end
    tests++;
    if (lost_evt !== 1'b0) begin fails++; $display("FAIL reset_lost got=%b exp=0", lost_evt); end
    tick();
    Rst_async_n = 1'b1;
    idle(8);
  endtask

  task automatic test_clean_coin();
    logic [1:0] exp;
    coin_50_raw = 1'b1;
    for (int e = 0; e < 10; e++) begin
      tick();
      exp = (e == 5) ? 2'b01 : 2'b00;
      tests++;
      if (X !== exp) begin fails++; $display("FAIL clean_X edge=%0d got=%b exp=%b", e, X, exp); end
    end
    tests++;
    if (jam_50 !== 1'b0) begin fails++; $display("FAIL clean_jam got=%b exp=0", jam_50); end
    coin_50_raw = 1'b0;
    for (int e = 0; e < 10; e++) begin
      tick();
      tests++;
      if (X !== 2'b00) begin fails++; $display("FAIL clean_fall_X edge=%0d got=%b exp=00", e, X); end
    end
  endtask

  task automatic test_bounce();
    logic [12:0] seq;
    int n10;
    int n01;
    seq = 13'b1111_1111_0110_1;  // bit i = sample driven before edge i
    seq = {8'hFF, 5'b01101};
    n10 = 0;
    n01 = 0;
    for (int e = 0; e < 25; e++) begin
      coin_100_raw = (e < 13) ? seq[e] : 1'b0;
      tick();
      if (X == 2'b10) n10++;
      if (X == 2'b01) n01++;
      if (e == 10) begin
        tests++;
        if (X !== 2'b10) begin fails++; $display("FAIL bounce_X_edge10 got=%b exp=10", X); end
      end
    end
    tests++;
    if (n10 != 1) begin fails++; $display("FAIL bounce_count10 got=%0d exp=1", n10); end
    tests++;
    if (n01 != 0) begin fails++; $display("FAIL bounce_count01 got=%0d exp=0", n01); end
    tests++;
    if (lost_evt !== 1'b0) begin fails++; $display("FAIL bounce_lost got=%b exp=0", lost_evt); end
    idle(6);
  endtask

  task automatic test_glitch();
    for (int e = 0; e < 12; e++) begin
      coin_50_raw = (e < 2);
      tick();
      tests++;
      if (X !== 2'b00) begin fails++; $display("FAIL glitch_X edge=%0d got=%b exp=00", e, X); end
    end
    idle(4);
  endtask

  task automatic test_simultaneous();
    logic [1:0] exp;
    for (int e = 0; e < 15; e++) begin
      coin_50_raw  = (e < 12);
      coin_100_raw = (e < 12);
      tick();
      exp = (e == 5) ? 2'b01 : (e == 8) ? 2'b10 : 2'b00;
      tests++;
      if (X !== exp) begin fails++; $display("FAIL simul_X edge=%0d got=%b exp=%b", e, X, exp); end
    end
    idle(10);
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp;
    for (int e = 0; e < 20; e++) begin
      coin_50_raw = (e < 4) || (e >= 8 && e < 12);
      tick();
      exp = (e == 5 || e == 13) ? 2'b01 : 2'b00;
      tests++;
      if (X !== exp) begin fails++; $display("FAIL repeat_X edge=%0d got=%b exp=%b", e, X, exp); end
    end
    tests++;
    if (lost_evt !== 1'b0) begin fails++; $display("FAIL repeat_lost got=%b exp=0", lost_evt); end
    idle(6);
  endtask

  task automatic test_reset_hold();
    logic [1:0] exp;
    Rst_async_n = 1'b0;
    coin_50_raw = 1'b1;
    tick();
    tests++;
    if (X !== 2'b00) begin fails++; $display("FAIL hold_in_reset_X got=%b exp=00", X); end
    tick();
    Rst_async_n = 1'b1;
    for (int e = 0; e < 60; e++) begin
      tick();
      tests++;
      if (X !== 2'b00) begin fails++; $display("FAIL hold_X edge=%0d got=%b exp=00", e, X); end
      if (e == 53) begin
        tests++;
        if (jam_50 !== 1'b0) begin fails++; $display("FAIL hold_jam_e53 got=%b exp=0", jam_50); end
      end
      if (e == 54 || e == 59) begin
        tests++;
        if (jam_50 !== 1'b1) begin fails++; $display("FAIL hold_jam edge=%0d got=%b exp=1", e, jam_50); end
      end
    end
    tests++;
    if (jam_100 !== 1'b0) begin fails++; $display("FAIL hold_jam100 got=%b exp=0", jam_100); end
    coin_50_raw = 1'b0;
    for (int e = 0; e < 10; e++) begin
      tick();
      tests++;
      if (X !== 2'b00) begin fails++; $display("FAIL release_X edge=%0d got=%b exp=00", e, X); end
      if (e == 3) begin
        tests++;
        if (jam_50 !== 1'b1) begin fails++; $display("FAIL release_jam_e3 got=%b exp=1", jam_50); end
      end
      if (e == 4) begin
        tests++;
        if (jam_50 !== 1'b0) begin fails++; $display("FAIL release_jam_e4 got=%b exp=0", jam_50); end
      end
    end
    // channel is armed now, so a fresh coin must be counted
    for (int e = 0; e < 10; e++) begin
      coin_50_raw = (e < 8);
      tick();
      exp = (e == 5) ? 2'b01 : 2'b00;
      tests++;
      if (X !== exp) begin fails++; $display("FAIL rearm_X edge=%0d got=%b exp=%b", e, X, exp); end
    end
    idle(6);
  endtask

  task automatic test_reset_mid_emit();
    coin_100_raw = 1'b1;
    for (int e = 0; e < 6; e++) tick();
    tests++;
    if (X !== 2'b10) begin fails++; $display("FAIL midrst_pre_X got=%b exp=10", X); end
    #2;
    Rst_async_n = 1'b0;
    #1;
    tests++;
    if (X !== 2'b00) begin fails++; $display("FAIL midrst_X got=%b exp=00", X); end
    tests++;
    if (lost_evt !== 1'b0) begin fails++; $display("FAIL midrst_lost got=%b exp=0", lost_evt); end
    coin_100_raw = 1'b0;
    tick();
    tick();
    Rst_async_n = 1'b1;
    idle(8);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_clean_coin();
    test_bounce();
    test_glitch();
    test_simultaneous();
    test_back_to_back();
    test_reset_hold();
    test_reset_mid_emit();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
